dds_sweep_ctrl: RTL

Frequency-sweep sequencer for the 6-bit-tuning-word DDS core. It drives the DDS frequency input with a programmed staircase of tuning words from f_start to f_stop in f_step increments, holding each word for a programmable dwell. It emits a one-cycle phase-reset pulse to the DDS at each sweep (re)start so every sweep begins at phase 0. Supported sweep shapes are single-shot, repeating sawtooth and repeating triangle.

---
 rtl/dds_sweep_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS core: steps freq_word from f_start to f_stop,
// holding each word dwell+1 cycles, in single-shot, sawtooth or triangle shape.
module dds_sweep_ctrl #(
  parameter int FW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic [1:0]    mode,
  output logic [FW-1:0] freq_word,
  output logic          dds_rst,
  output logic          busy,
  output logic          done,
  output logic          wrap
);

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

  state_t        state;
  logic [FW-1:0] fs_r, fe_r, st_r, target;
  logic [DW-1:0] dwell_r, cnt;
  logic [1:0]    mode_r;
  logic          accept;
  logic [FW-1:0] tgt_swap;

  // One step toward tgt, clamped so the endpoint is hit exactly and never wrapped past.
  function automatic logic [FW-1:0] step_toward(input logic [FW-1:0] cur,
                                                input logic [FW-1:0] tgt,
                                                input logic [FW-1:0] stp);
    logic signed [FW+1:0] c, t, s, n;
    c = $signed({2'b00, cur});
    t = $signed({2'b00, tgt});
    s = $signed({2'b00, stp});
    if (cur <= tgt) begin
      n = c + s;
      if (n > t) n = t;
    end else begin
      n = c - s;
      if (n < t) n = t;
    end
    return n[FW-1:0];
  endfunction

  assign accept   = (state == IDLE) && start && !abort;
  assign tgt_swap = (target == fe_r) ? fs_r : fe_r;

  // Sweep configuration is pure data: captured on acceptance, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      fs_r    <= f_start;
      fe_r    <= f_stop;
      st_r    <= (f_step == '0) ? FW'(1) : f_step;
      dwell_r <= dwell;
      mode_r  <= mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      freq_word <= '0;
      dds_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      cnt       <= '0;
      target    <= '0;
    end else begin
      dds_rst <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= DWELL;
            freq_word <= f_start;
            dds_rst   <= 1'b1;
            busy      <= 1'b1;
            cnt       <= dwell;
            target    <= f_stop;
          end
        end
        DWELL: begin
          if (abort) begin
            state     <= IDLE;
            freq_word <= '0;
            busy      <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - DW'(1);
          end else if (freq_word != target) begin
            freq_word <= step_toward(freq_word, target, st_r);
            cnt       <= dwell_r;
          end else begin
            case (mode_r)
              2'b01: begin
                freq_word <= fs_r;
                dds_rst   <= 1'b1;
                wrap      <= 1'b1;
                cnt       <= dwell_r;
              end
              2'b10: begin
                // Turnaround takes the first step immediately so the endpoint is not held twice.
                target    <= tgt_swap;
                freq_word <= step_toward(freq_word, tgt_swap, st_r);
                wrap      <= 1'b1;
                cnt       <= dwell_r;
              end
              default: begin
                state     <= DONE;
                freq_word <= '0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            endcase
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
